// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: configurable divisor, width and parity, framing/parity checks and a
// DEPTH-entry read-ahead FIFO with sticky overrun. Define UART_RX_MAJORITY_EN for 3-sample majority voting.
module uart_rx_param #(
  parameter int CLK_DIV   = 2604,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int DEPTH     = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     RX,
  input  logic                     clr_rdy,
  input  logic                     ovr_clr,
  output logic                     rdy,
  output logic [DATA_BITS-1:0]     rx_data,
  output logic                     par_err,
  output logic                     frm_err,
  output logic                     overrun,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     busy
);
  localparam int CW  = $clog2(CLK_DIV);
  localparam int AW  = $clog2(DEPTH);
  localparam int CNW = AW + 1;
  localparam int EW  = DATA_BITS + 2;
  localparam logic [CW-1:0]  HALF_CNT = CW'(CLK_DIV / 2);
  localparam logic [CW-1:0]  FULL_CNT = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(32'd1);
  localparam logic [AW-1:0]  PTR_ONE  = AW'(32'd1);
  localparam logic [CNW-1:0] OCC_ONE  = CNW'(32'd1);
  localparam logic [CNW-1:0] OCC_FULL = CNW'(DEPTH);
  localparam logic [3:0]     LAST_BIT = 4'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_PAR   = 3'd3,
    S_STOP  = 3'd4
  } state_t;

  function automatic logic calc_par_err(input logic [DATA_BITS-1:0] d, input logic pbit);
    return ((^d) ^ pbit) != (PARITY == 2);
  endfunction

  state_t                 state_r, state_s;
  logic                   rx_meta_r, rx_sync_r;
  logic [CW-1:0]          baud_cnt_r;
  logic                   strobe_s, bit_stb_s, bit_val_s, push_s;
  logic [3:0]             bit_idx_r;
  logic [DATA_BITS-1:0]   shift_r;
  logic                   par_err_r;
  logic [EW-1:0]          entry_s;
  logic [EW-1:0]          mem_r [DEPTH];
  logic [AW-1:0]          wr_ptr_r, rd_ptr_r;
  logic [CNW-1:0]         count_r;
  logic                   overrun_r;
  logic                   full_s, pop_s, wr_en_s, drop_s;

  // Two-flop synchroniser on the asynchronous RX pin, idling high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
    end else begin
      rx_meta_r <= RX;
      rx_sync_r <= rx_meta_r;
    end
  end

  assign strobe_s = (state_r != S_IDLE) && (baud_cnt_r == '0);

  // Baud down-counter: half-bit load on start detect, full-bit reload on each strobe, frozen in IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_cnt_r <= '0;
    end else if (state_r == S_IDLE) begin
      if (!rx_sync_r) baud_cnt_r <= HALF_CNT;
    end else if (strobe_s) begin
      baud_cnt_r <= FULL_CNT;
    end else begin
      baud_cnt_r <= baud_cnt_r - CNT_ONE;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic samp1_r, samp0_r, stb_d_r;

  // Hold the counter=1 and counter=0 samples; the vote completes with the first post-reload sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp1_r <= 1'b1;
      samp0_r <= 1'b1;
      stb_d_r <= 1'b0;
    end else begin
      stb_d_r <= strobe_s;
      if (baud_cnt_r == CNT_ONE) samp1_r <= rx_sync_r;
      if (strobe_s) samp0_r <= rx_sync_r;
    end
  end

  assign bit_stb_s = stb_d_r;
  assign bit_val_s = (samp1_r & samp0_r) | (samp1_r & rx_sync_r) | (samp0_r & rx_sync_r);
`else
  assign bit_stb_s = strobe_s;
  assign bit_val_s = rx_sync_r;
`endif

  // Frame sequencing; a stop-bit commit returns to IDLE at once so back-to-back starts are not missed
  always_comb begin
    state_s = state_r;
    push_s  = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (!rx_sync_r) state_s = S_START;
        else            state_s = S_IDLE;
      end
      S_START: begin
        if (bit_stb_s) state_s = bit_val_s ? S_IDLE : S_DATA;
        else           state_s = S_START;
      end
      S_DATA: begin
        if (bit_stb_s && (bit_idx_r == LAST_BIT)) state_s = (PARITY != 0) ? S_PAR : S_STOP;
        else                                      state_s = S_DATA;
      end
      S_PAR: begin
        if (bit_stb_s) state_s = S_STOP;
        else           state_s = S_PAR;
      end
      S_STOP: begin
        if (bit_stb_s) begin
          state_s = S_IDLE;
          push_s  = 1'b1;
        end else begin
          state_s = S_STOP;
        end
      end
      default: state_s = S_IDLE;
    endcase
  end

  // State register plus the data/parity capture that follows each committed bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= S_IDLE;
      bit_idx_r <= 4'd0;
      shift_r   <= '0;
      par_err_r <= 1'b0;
    end else begin
      state_r <= state_s;
      if (state_r == S_IDLE) begin
        bit_idx_r <= 4'd0;
        par_err_r <= 1'b0;
      end else if (bit_stb_s && (state_r == S_DATA)) begin
        shift_r   <= {bit_val_s, shift_r[DATA_BITS-1:1]};
        bit_idx_r <= bit_idx_r + 4'd1;
      end else if (bit_stb_s && (state_r == S_PAR)) begin
        par_err_r <= calc_par_err(shift_r, bit_val_s);
      end
    end
  end

  assign entry_s = {~bit_val_s, par_err_r, shift_r};
  assign full_s  = (count_r == OCC_FULL);
  assign pop_s   = clr_rdy && (count_r != '0);
  // A pop frees the head slot in the same cycle, so a full FIFO can still accept a push alongside it
  assign wr_en_s = push_s && (!full_s || pop_s);
  assign drop_s  = push_s && full_s && !pop_s;

  // FIFO storage, pointers, occupancy and sticky overrun (a new drop beats a clear)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
      wr_ptr_r  <= '0;
      rd_ptr_r  <= '0;
      count_r   <= '0;
      overrun_r <= 1'b0;
    end else begin
      if (wr_en_s) begin
        mem_r[wr_ptr_r] <= entry_s;
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) rd_ptr_r <= rd_ptr_r + PTR_ONE;
      if (wr_en_s && !pop_s)      count_r <= count_r + OCC_ONE;
      else if (!wr_en_s && pop_s) count_r <= count_r - OCC_ONE;
      if (drop_s)       overrun_r <= 1'b1;
      else if (ovr_clr) overrun_r <= 1'b0;
    end
  end

  assign rdy     = (count_r != '0);
  assign count   = count_r;
  assign overrun = overrun_r;
  assign busy    = (state_r != S_IDLE);
  assign rx_data = mem_r[rd_ptr_r][DATA_BITS-1:0];
  assign par_err = mem_r[rd_ptr_r][DATA_BITS];
  assign frm_err = mem_r[rd_ptr_r][DATA_BITS+1];

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: two instances (no parity / even parity), frame-level reference model
// with a per-cycle compare, directed scenarios and randomized traffic.
module tb_uart_rx_param;
  localparam int CD    = 16;
  localparam int DEPTH = 4;
`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx [2];
  logic       clr_rdy [2];
  logic       ovr_clr [2];
  logic       rdy_w [2];
  logic [7:0] data_w [2];
  logic       par_w [2];
  logic       frm_w [2];
  logic       ovr_w [2];
  logic       busy_w [2];
  logic [2:0] cnt_w [2];

  always #5 clk = ~clk;

  uart_rx_param #(.CLK_DIV(CD), .DATA_BITS(8), .PARITY(0), .DEPTH(DEPTH)) u0 (
    .clk(clk), .rst_n(rst_n), .RX(rx[0]), .clr_rdy(clr_rdy[0]), .ovr_clr(ovr_clr[0]),
    .rdy(rdy_w[0]), .rx_data(data_w[0]), .par_err(par_w[0]), .frm_err(frm_w[0]),
    .overrun(ovr_w[0]), .count(cnt_w[0]), .busy(busy_w[0]));

  uart_rx_param #(.CLK_DIV(CD), .DATA_BITS(8), .PARITY(1), .DEPTH(DEPTH)) u1 (
    .clk(clk), .rst_n(rst_n), .RX(rx[1]), .clr_rdy(clr_rdy[1]), .ovr_clr(ovr_clr[1]),
    .rdy(rdy_w[1]), .rx_data(data_w[1]), .par_err(par_w[1]), .frm_err(frm_w[1]),
    .overrun(ovr_w[1]), .count(cnt_w[1]), .busy(busy_w[1]));

  // Reference model: an ordered list of received entries {frm, par, data} per instance
  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;
  logic [9:0] mq [2][8];
  int         msz [2];
  logic       movr [2];
  logic       mvalid = 1'b0;
  int         pdue [2];
  logic [9:0] pent [2];
  int         bfrom [2], bto [2], mfrom [2], mto [2];
  logic       done0, done1;

  function automatic int par_mode(input int i);
    return (i == 1) ? 1 : 0;
  endfunction

  // Edges from the start-bit drive to the FIFO push: 2 sync flops + detect, half bit to the start
  // centre, one strobe-to-push edge, then one full bit per remaining frame bit.
  function automatic int lat(input int i);
    return 3 + CD / 2 + 1 + (1 + 8 + ((par_mode(i) != 0) ? 1 : 0)) * CD + MAJ;
  endfunction

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL u%0d %s: got %0h, expected %0h (cycle %0d)", i, nm, act, exp, cyc);
    end
  endtask

  // Model update on every active edge, from the same inputs the DUT sees
  initial begin
    logic pop_ok;
    forever begin
      @(posedge clk);
      cyc++;
      mvalid = rst_n;
      for (int i = 0; i < 2; i++) begin
        if (!rst_n) begin
          msz[i] = 0; movr[i] = 1'b0; pdue[i] = -1;
          bfrom[i] = 0; bto[i] = 0; mfrom[i] = 0; mto[i] = 0;
        end else begin
          pop_ok = clr_rdy[i] && (msz[i] > 0);
          if (pop_ok) begin
            for (int k = 0; k < 7; k++) mq[i][k] = mq[i][k+1];
            msz[i]--;
          end
          if (pdue[i] == cyc && msz[i] == DEPTH) begin
            movr[i] = 1'b1;
          end else begin
            if (pdue[i] == cyc) begin
              mq[i][msz[i]] = pent[i];
              msz[i]++;
            end
            if (ovr_clr[i]) movr[i] = 1'b0;
          end
        end
      end
    end
  end

  // Per-cycle compare away from the active edge
  initial begin
    forever begin
      @(negedge clk);
      if (mvalid && rst_n) begin
        for (int i = 0; i < 2; i++) begin
          chk("rdy", i, rdy_w[i], msz[i] != 0);
          chk("count", i, cnt_w[i], msz[i]);
          chk("overrun", i, ovr_w[i], movr[i]);
          if (!(cyc >= mfrom[i] && cyc < mto[i]))
            chk("busy", i, busy_w[i], (cyc >= bfrom[i]) && (cyc < bto[i]));
          if (msz[i] != 0) begin
            chk("rx_data", i, data_w[i], mq[i][0][7:0]);
            chk("par_err", i, par_w[i], mq[i][0][8]);
            chk("frm_err", i, frm_w[i], mq[i][0][9]);
          end
        end
      end
    end
  end

  task automatic send_frame(input int i, input logic [7:0] d, input logic pbit, input logic stopb);
    logic bits [12];
    int   nb;
    int   e0;
    logic pe;
    @(negedge clk);
    e0 = cyc;
    bits[0] = 1'b0;
    for (int b = 0; b < 8; b++) bits[1+b] = d[b];
    nb = 9;
    if (par_mode(i) != 0) begin
      bits[9] = pbit;
      nb = 10;
    end
    bits[nb] = stopb;
    nb = nb + 1;
    pe = (par_mode(i) != 0) && ((($countones(d) + int'(pbit)) % 2) != ((par_mode(i) == 2) ? 1 : 0));
    pent[i]  = {~stopb, pe, d};
    pdue[i]  = e0 + lat(i);
    bfrom[i] = e0 + 3;
    bto[i]   = pdue[i];
    // A low stop bit is seen again as a start once the receiver is idle; that short false start is not modelled
    if (!stopb) begin
      mfrom[i] = pdue[i];
      mto[i]   = pdue[i] + CD;
    end
    for (int b = 0; b < nb; b++) begin
      rx[i] = bits[b];
      repeat ((b == nb - 1) ? CD - 1 : CD) @(negedge clk);
    end
    rx[i] = 1'b1;
    if (!stopb) repeat (CD) @(negedge clk);
  endtask

  task automatic pop(input int i);
    @(negedge clk);
    clr_rdy[i] = 1'b1;
    @(negedge clk);
    clr_rdy[i] = 1'b0;
  endtask

  task automatic glitch(input int i);
    int e0;
    @(negedge clk);
    e0 = cyc;
    bfrom[i] = e0 + 3;
    bto[i]   = e0 + 3 + CD / 2 + 1 + MAJ;
    rx[i] = 1'b0;
    repeat (4) @(negedge clk);
    rx[i] = 1'b1;
    repeat (2 * CD) @(negedge clk);
    chk("glitch busy", i, busy_w[i], 1'b0);
    chk("glitch count", i, cnt_w[i], 3'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    int e0;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rx[i] = 1'b1; clr_rdy[i] = 1'b0; ovr_clr[i] = 1'b0;
      msz[i] = 0; movr[i] = 1'b0; pdue[i] = -1;
      bfrom[i] = 0; bto[i] = 0; mfrom[i] = 0; mto[i] = 0;
    end
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("reset rdy", i, rdy_w[i], 1'b0);
      chk("reset count", i, cnt_w[i], 3'd0);
      chk("reset overrun", i, ovr_w[i], 1'b0);
      chk("reset busy", i, busy_w[i], 1'b0);
      chk("reset rx_data", i, data_w[i], 8'h00);
    end

    // Basic 8N1 frame
    send_frame(0, 8'hA5, 1'b0, 1'b1);
    chk("basic rdy", 0, rdy_w[0], 1'b1);
    chk("basic data", 0, data_w[0], 8'hA5);
    chk("basic par", 0, par_w[0], 1'b0);
    chk("basic frm", 0, frm_w[0], 1'b0);
    chk("basic count", 0, cnt_w[0], 3'd1);
    chk("model size", 0, msz[0], 1);
    pop(0);
    chk("pop rdy", 0, rdy_w[0], 1'b0);
    chk("pop count", 0, cnt_w[0], 3'd0);

    // Even parity, good then bad parity bit
    send_frame(1, 8'h03, 1'b0, 1'b1);
    chk("even ok par", 1, par_w[1], 1'b0);
    chk("even ok data", 1, data_w[1], 8'h03);
    pop(1);
    send_frame(1, 8'h03, 1'b1, 1'b1);
    chk("even bad par", 1, par_w[1], 1'b1);
    chk("even bad data", 1, data_w[1], 8'h03);
    chk("model par", 1, mq[1][0][8], 1'b1);
    pop(1);

    // Framing error followed by a good frame
    send_frame(0, 8'h5A, 1'b0, 1'b0);
    chk("frm data", 0, data_w[0], 8'h5A);
    chk("frm err", 0, frm_w[0], 1'b1);
    send_frame(0, 8'h11, 1'b0, 1'b1);
    chk("frm count", 0, cnt_w[0], 3'd2);
    pop(0);
    chk("frm second data", 0, data_w[0], 8'h11);
    chk("frm second err", 0, frm_w[0], 1'b0);
    pop(0);

    // Overrun: five frames into a four-entry FIFO
    for (int v = 1; v <= 5; v++) send_frame(0, 8'(v), 1'b0, 1'b1);
    chk("ovr count", 0, cnt_w[0], 3'd4);
    chk("ovr flag", 0, ovr_w[0], 1'b1);
    for (int v = 1; v <= 4; v++) begin
      chk("ovr order", 0, data_w[0], 8'(v));
      chk("ovr sticky", 0, ovr_w[0], 1'b1);
      pop(0);
    end
    @(negedge clk);
    ovr_clr[0] = 1'b1;
    @(negedge clk);
    ovr_clr[0] = 1'b0;
    chk("ovr cleared", 0, ovr_w[0], 1'b0);

    // Short low pulse on RX is rejected at the start-bit check
    glitch(0);
    glitch(1);

    // Reset in the middle of data bit 3, then a clean frame
    @(negedge clk);
    e0 = cyc;
    bfrom[0] = e0 + 3;
    bto[0]   = e0 + 100000;
    rx[0] = 1'b0;
    repeat (CD) @(negedge clk);
    rx[0] = 1'b1;
    repeat (CD) @(negedge clk);
    rx[0] = 1'b0;
    repeat (CD) @(negedge clk);
    rx[0] = 1'b1;
    repeat (CD) @(negedge clk);
    rx[0] = 1'b0;
    repeat (CD / 2) @(negedge clk);
    chk("mid busy", 0, busy_w[0], 1'b1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    rx[0] = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("post-reset busy", 0, busy_w[0], 1'b0);
    chk("post-reset count", 0, cnt_w[0], 3'd0);
    send_frame(0, 8'h7E, 1'b0, 1'b1);
    chk("resync data", 0, data_w[0], 8'h7E);
    chk("resync count", 0, cnt_w[0], 3'd1);
    pop(0);

    // Full FIFO: push and pop land on the same edge
    for (int v = 0; v < 4; v++) send_frame(0, 8'(8'h21 + v), 1'b0, 1'b1);
    chk("full count", 0, cnt_w[0], 3'd4);
    fork
      send_frame(0, 8'h25, 1'b0, 1'b1);
      begin
        @(negedge clk);
        repeat (lat(0) - 1) @(negedge clk);
        clr_rdy[0] = 1'b1;
        @(negedge clk);
        clr_rdy[0] = 1'b0;
      end
    join
    chk("pp count", 0, cnt_w[0], 3'd4);
    chk("pp overrun", 0, ovr_w[0], 1'b0);
    for (int v = 2; v <= 5; v++) begin
      chk("pp order", 0, data_w[0], 8'(8'h20 + v));
      pop(0);
    end

    // Randomized traffic on both instances with random pops and overrun clears
    done0 = 1'b0;
    done1 = 1'b0;
    fork
      begin
        for (int n = 0; n < 10; n++)
          send_frame(0, 8'($urandom()), 1'b0, $urandom_range(0, 5) != 0);
        done0 = 1'b1;
      end
      begin
        for (int n = 0; n < 10; n++)
          send_frame(1, 8'($urandom()), $urandom_range(0, 3) == 0, $urandom_range(0, 5) != 0);
        done1 = 1'b1;
      end
      begin
        for (int t = 0; t < 6000 && !(done0 && done1); t++) begin
          @(negedge clk);
          clr_rdy[0] = ($urandom_range(0, 299) == 0);
          clr_rdy[1] = ($urandom_range(0, 199) == 0);
          ovr_clr[0] = ($urandom_range(0, 399) == 0);
          ovr_clr[1] = ($urandom_range(0, 399) == 0);
        end
        @(negedge clk);
        clr_rdy[0] = 1'b0; clr_rdy[1] = 1'b0;
        ovr_clr[0] = 1'b0; ovr_clr[1] = 1'b0;
      end
    join
    repeat (8) begin
      pop(0);
      pop(1);
    end
    repeat (4) @(negedge clk);
    chk("drain count", 0, cnt_w[0], 3'd0);
    chk("drain count", 1, cnt_w[1], 3'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
- Parametrised UART receiver; successor to the fixed 8N1 / 19200-baud receiver.
- Adds configurable divisor, data width and parity, plus framing-error and parity-error detection.
- Adds a DEPTH-entry receive FIFO with overrun flag, so the core can fall behind by several bytes without loss.
- Sits between the async RX pin and the command/protocol layer.

Parameters:
- CLK_DIV, 2604, clk cycles per bit (50 MHz / 19200); minimum 8.
- DATA_BITS, 8, data bits per frame, 5..9, LSB first.
- PARITY, 0, parity mode: 0 = none, 1 = even, 2 = odd.
- DEPTH, 4, FIFO entries, power of 2, >= 2.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous, active-low.
- RX  input  1  async serial input; idle high.
- clr_rdy  input  1  pop head entry; ignored when FIFO empty.
- ovr_clr  input  1  clears sticky overrun.
- rdy  output  1  FIFO non-empty.
- rx_data  output  DATA_BITS  head entry data.
- par_err  output  1  head entry parity error; always 0 when PARITY = 0.
- frm_err  output  1  head entry stop bit sampled 0.
- overrun  output  1  sticky; a frame was dropped because the FIFO was full.
- count  output  $clog2(DEPTH)+1  FIFO occupancy.
- busy  output  1  state != IDLE.

Behaviour:
- RX sync: double-flopped to rx_sync; both flops reset to 1. All decisions use rx_sync.
- Baud counter: down-counter, width $clog2(CLK_DIV). Sample strobe fires when counter = 0.
  - Loaded with CLK_DIV/2 on start detect.
  - Reloaded with CLK_DIV-1 on each strobe.
  - Holds in IDLE.
- FSM states:
  - IDLE: rx_sync = 0 -> START, load half-count.
  - START: on strobe, rx_sync = 1 -> IDLE (glitch; nothing pushed, no error). Else -> DATA, bit index = 0.
  - DATA: on strobe, shift rx_sync into MSB of data shift register. After DATA_BITS samples -> PARITY if PARITY != 0, else STOP.
  - PARITY: on strobe, par_err_next = (XOR of data bits ^ rx_sync) != (PARITY == 2).
  - STOP: on strobe, frm_err_next = ~rx_sync. Push {frm_err, par_err, data} to FIFO; -> IDLE on the same edge.
- Back-to-back frames: returning to IDLE mid-stop-bit lets the next start edge be caught with no dead time.
- Push latency: rdy, rx_data and count update on the clk edge after the stop-bit strobe.
- FIFO:
  - Read-ahead: outputs show the head entry combinationally from storage.
  - Pointers are $clog2(DEPTH) bits and wrap naturally.
- Boundary conditions:
  - Push while full, no pop: frame dropped, overrun <= 1, FIFO contents unchanged.
  - Push and pop in the same cycle while full: both occur, count unchanged, no overrun.
  - Push and pop in the same cycle while empty: push only.
  - Pop while empty: no effect.
  - overrun set and ovr_clr in the same cycle: set wins.
- Reset values: rdy = 0, count = 0, overrun = 0, busy = 0, state IDLE, pointers 0. rx_data, par_err and frm_err are 0 (storage reset).
- Reset mid-frame: frame discarded; the receiver resynchronises on the next falling edge after rst_n deasserts.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- When defined:
  - Each strobe's bit value is the majority of three rx_sync samples taken at counter = 1, 0 and CLK_DIV-1 (the cycle after reload).
  - The bit value commits one cycle after the strobe.
  - The START glitch check uses the majority value.
  - FIFO push latency grows by 1 cycle.
- When undefined: single sample at counter = 0, as described above.

Test Plan:
- Basic frame (CLK_DIV = 16, 8N1): send 0xA5 -> rdy rises 1 clk after the stop strobe; rx_data = 0xA5, par_err = 0, frm_err = 0, count = 1. clr_rdy pulse -> rdy = 0, count = 0.
- Even parity (PARITY = 1): send 0x03 with parity bit 0 -> par_err = 0. Send 0x03 with parity bit 1 -> par_err = 1, data still 0x03.
- Framing error: send 0x5A with stop bit 0 -> frm_err = 1, rx_data = 0x5A. Then a correct 0x11 frame -> second entry 0x11 with frm_err = 0.
- Overrun (DEPTH = 4): 5 back-to-back frames 0x01..0x05 with no pops -> count = 4, overrun = 1, popped order 0x01..0x04. ovr_clr -> overrun = 0.
- Glitch and reset: RX low for 4 clks (CLK_DIV = 16) -> returns to IDLE with count = 0, busy = 0. rst_n asserted at data bit 3 of a frame -> busy = 0, count = 0; the next full frame 0x7E is received correctly.
- Full push+pop: FIFO full and a stop strobe coincides with clr_rdy -> count stays 4, overrun stays 0, newest entry at tail.
